// File: rtl/mem_access_stage_pkg.sv
// Shared load/store op codes, stage states and access-size helpers for the MEM stage.
package mem_access_stage_pkg;

  localparam logic [3:0] LS_NONE = 4'd0;
  localparam logic [3:0] LS_LB   = 4'd1;
  localparam logic [3:0] LS_LBU  = 4'd2;
  localparam logic [3:0] LS_LH   = 4'd3;
  localparam logic [3:0] LS_LHU  = 4'd4;
  localparam logic [3:0] LS_LW   = 4'd5;
  localparam logic [3:0] LS_LWU  = 4'd6;
  localparam logic [3:0] LS_LD   = 4'd7;
  localparam logic [3:0] LS_SB   = 4'd8;
  localparam logic [3:0] LS_SH   = 4'd9;
  localparam logic [3:0] LS_SW   = 4'd10;
  localparam logic [3:0] LS_SD   = 4'd11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } mem_state_e;

  // Access size in bytes; 0 for ALU ops.
  function automatic int unsigned ls_bytes(input logic [3:0] op);
    case (op)
      LS_LB, LS_LBU, LS_SB: return 1;
      LS_LH, LS_LHU, LS_SH: return 2;
      LS_LW, LS_LWU, LS_SW: return 4;
      LS_LD, LS_SD:         return 8;
      default:              return 0;
    endcase
  endfunction

  function automatic logic ls_signed(input logic [3:0] op);
    return (op == LS_LB) || (op == LS_LH) || (op == LS_LW) || (op == LS_LD);
  endfunction

  function automatic logic ls_is_load(input logic [3:0] op);
    return (op >= LS_LB) && (op <= LS_LD);
  endfunction

  function automatic logic ls_misaligned(input logic [3:0] op, input logic [2:0] lane);
    int unsigned nb;
    nb = ls_bytes(op);
    if (nb == 0) return 1'b0;
    return |(lane & 3'(nb - 1));
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// Lane select plus sign/zero extension of SRAM read data to a full DATA_W result.
module mem_access_stage_load_align_ext
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        op_i,
  input  logic [2:0]        lane_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned IDX_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shifted;
  logic [5:0]        shamt;
  logic [IDX_W-1:0]  sign_idx;
  int unsigned       nbits;
  logic              fill;

  always_comb begin
    shamt   = {lane_i, 3'b000};
    shifted = rdata_i >> shamt;
    nbits   = 8 * ls_bytes(op_i);
    if (nbits == 0 || nbits > DATA_W) nbits = DATA_W;
    sign_idx = IDX_W'(nbits - 1);
    fill     = ls_signed(op_i) & shifted[sign_idx];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      data_o[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: registers the EX payload, waits on a valid/ready SRAM response,
// aligns/extends load data and flags misaligned accesses and response timeouts.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RF_AW   = 5,
  parameter int unsigned TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_addr_lo,
  input  logic              in_rf_we,
  input  logic [RF_AW-1:0]  in_rf_waddr,
  input  logic [DATA_W-1:0] in_ex_result,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_ready,
  output logic              stall_req,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_rf_we,
  output logic [RF_AW-1:0]  out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  output logic              addr_err,
  output logic              tmo_err
);

  localparam int unsigned LANE_W    = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W     = $clog2(TMO_CYC + 1);
  localparam logic [2:0]  LANE_MASK = 3'((1 << LANE_W) - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pl_valid_q, pl_valid_d;
  logic [ADDR_W-1:0] pl_pc_q, pl_pc_d;
  logic [3:0]        pl_op_q, pl_op_d;
  logic [2:0]        pl_lane_q, pl_lane_d;
  logic              pl_rf_we_q, pl_rf_we_d;
  logic [RF_AW-1:0]  pl_waddr_q, pl_waddr_d;
  logic [DATA_W-1:0] pl_res_q, pl_res_d;

  logic [2:0]        in_lane;
  logic [DATA_W-1:0] align_data;
  logic              pl_misal;
  logic              leave;

  assign in_lane      = in_addr_lo & LANE_MASK;
  assign pl_misal     = ls_misaligned(pl_op_q, pl_lane_q);
  assign out_pc       = pl_pc_q;
  assign out_rf_waddr = pl_waddr_q;

  mem_access_stage_load_align_ext #(
    .DATA_W(DATA_W)
  ) u_align (
    .op_i   (pl_op_q),
    .lane_i (pl_lane_q),
    .rdata_i(rsp_rdata),
    .data_o (align_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    pl_valid_d   = pl_valid_q;
    pl_pc_d      = pl_pc_q;
    pl_op_d      = pl_op_q;
    pl_lane_d    = pl_lane_q;
    pl_rf_we_d   = pl_rf_we_q;
    pl_waddr_d   = pl_waddr_q;
    pl_res_d     = pl_res_q;
    rsp_ready    = 1'b0;
    stall_req    = 1'b0;
    out_valid    = 1'b0;
    out_rf_we    = 1'b0;
    out_rf_wdata = pl_res_q;
    addr_err     = 1'b0;
    tmo_err      = 1'b0;
    leave        = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_valid = pl_valid_q;
        addr_err  = pl_valid_q & pl_misal;
        out_rf_we = pl_valid_q & pl_rf_we_q & ~pl_misal;
      end
      StWait: begin
        stall_req = 1'b1;
        rsp_ready = 1'b1;
        if (flush) begin
          leave = 1'b1;
        end else if (rsp_valid && !stall) begin
          out_valid    = 1'b1;
          out_rf_we    = pl_rf_we_q;
          out_rf_wdata = align_data;
          leave        = 1'b1;
        end else if (rsp_valid) begin
          hold_d  = align_data;
          state_d = StHold;
        end else if (!stall) begin
          // A response in the same cycle takes priority over the timeout.
          if (cnt_q == CNT_W'(TMO_CYC)) begin
            out_valid = 1'b1;
            tmo_err   = 1'b1;
            leave     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StHold: begin
        stall_req = 1'b1;
        if (flush) begin
          leave = 1'b1;
        end else if (!stall) begin
          out_valid    = 1'b1;
          out_rf_we    = pl_rf_we_q;
          out_rf_wdata = hold_q;
          leave        = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Retiring a load empties the payload so IDLE does not replay it.
    if (leave) begin
      state_d    = StIdle;
      pl_valid_d = 1'b0;
    end else if (!stall && !stall_req) begin
      pl_valid_d = in_valid & ~flush;
      pl_pc_d    = in_pc;
      pl_op_d    = in_op;
      pl_lane_d  = in_lane;
      pl_rf_we_d = in_rf_we;
      pl_waddr_d = in_rf_waddr;
      pl_res_d   = in_ex_result;
      if (in_valid && !flush && ls_is_load(in_op) && !ls_misaligned(in_op, in_lane)) begin
        state_d = StWait;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hold_q     <= '0;
      pl_valid_q <= 1'b0;
      pl_pc_q    <= '0;
      pl_op_q    <= '0;
      pl_lane_q  <= '0;
      pl_rf_we_q <= 1'b0;
      pl_waddr_q <= '0;
      pl_res_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      pl_valid_q <= pl_valid_d;
      pl_pc_q    <= pl_pc_d;
      pl_op_q    <= pl_op_d;
      pl_lane_q  <= pl_lane_d;
      pl_rf_we_q <= pl_rf_we_d;
      pl_waddr_q <= pl_waddr_d;
      pl_res_q   <= pl_res_d;
    end
  end

endmodule
